intra16_mode_sched: RTL



---
 rtl/intra16_mode_sched_if.sv | 50 +++++
 rtl/intra16_mode_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/intra16_mode_sched_if.sv
// Handshake and datapath bundle for the 16x16 intra mode scheduler.
interface intra16_mode_sched_if #(
    parameter int COST_W = 16
);
    logic              mb_valid;
    logic              mb_ready;
    logic              top_avail;
    logic              left_avail;
    logic              pred_start;
    logic [1:0]        pred_mode;
    logic              pred_done;
    logic [COST_W-1:0] pred_cost;
    logic              result_valid;
    logic [1:0]        best_mode;
    logic [COST_W-1:0] best_cost;
    logic              busy;
    logic              timeout_err;

    modport master (
        output mb_valid,
        output top_avail,
        output left_avail,
        output pred_done,
        output pred_cost,
        input  mb_ready,
        input  pred_start,
        input  pred_mode,
        input  result_valid,
        input  best_mode,
        input  best_cost,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  mb_valid,
        input  top_avail,
        input  left_avail,
        input  pred_done,
        input  pred_cost,
        output mb_ready,
        output pred_start,
        output pred_mode,
        output result_valid,
        output best_mode,
        output best_cost,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/intra16_mode_sched.sv
// 16x16 luma intra mode scheduler: runs legal modes, keeps the cheapest.
// Define INTRA16_PLANE_EN to also evaluate plane prediction (mode 3).
module intra16_mode_sched #(
    parameter int COST_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    intra16_mode_sched_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [COST_W-1:0] COST_MAX = '1;

`ifdef INTRA16_PLANE_EN
    localparam logic PLANE = 1'b1;
`else
    localparam logic PLANE = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        COMPARE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [1:0]        mode_q;
    logic [1:0]        mode_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [COST_W-1:0] cost_q;
    logic [COST_W-1:0] cost_n;
    logic [1:0]        bmode;
    logic [1:0]        bmode_n;
    logic [COST_W-1:0] bcost;
    logic [COST_W-1:0] bcost_n;
    logic              terr;
    logic              terr_n;
    logic              top_q;
    logic              top_n;
    logic              left_q;
    logic              left_n;

    logic [1:0]        first_mode;
    logic              nxt_valid;
    logic [1:0]        nxt_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mode_q <= 2'd0;
            cnt    <= '0;
            cost_q <= '0;
            bmode  <= 2'd2;
            bcost  <= '0;
            terr   <= 1'b0;
            top_q  <= 1'b0;
            left_q <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            cnt    <= cnt_n;
            cost_q <= cost_n;
            bmode  <= bmode_n;
            bcost  <= bcost_n;
            terr   <= terr_n;
            top_q  <= top_n;
            left_q <= left_n;
        end
    end

    always_comb begin
        first_mode = 2'd2;
        if (bus.top_avail) begin
            first_mode = 2'd0;
        end else if (bus.left_avail) begin
            first_mode = 2'd1;
        end
    end

    // Successor of the mode just evaluated; illegal modes cost no cycles.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_mode  = 2'd2;
        unique case (mode_q)
            2'd0: begin
                nxt_valid = 1'b1;
                nxt_mode  = left_q ? 2'd1 : 2'd2;
            end
            2'd1: begin
                nxt_valid = 1'b1;
                nxt_mode  = 2'd2;
            end
            2'd2: begin
                nxt_valid = PLANE & top_q & left_q;
                nxt_mode  = 2'd3;
            end
            2'd3: begin
                nxt_valid = 1'b0;
                nxt_mode  = 2'd2;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        cnt_n   = cnt;
        cost_n  = cost_q;
        bmode_n = bmode;
        bcost_n = bcost;
        terr_n  = terr;
        top_n   = top_q;
        left_n  = left_q;
        unique case (state)
            IDLE: begin
                if (bus.mb_valid) begin
                    top_n   = bus.top_avail;
                    left_n  = bus.left_avail;
                    bcost_n = COST_MAX;
                    bmode_n = first_mode;
                    terr_n  = 1'b0;
                    mode_n  = first_mode;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.pred_done) begin
                    cost_n  = bus.pred_cost;
                    state_n = COMPARE;
                end else if (cnt == CNT_LAST) begin
                    cost_n  = COST_MAX;
                    terr_n  = 1'b1;
                    state_n = COMPARE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            COMPARE: begin
                if (cost_q < bcost) begin
                    bcost_n = cost_q;
                    bmode_n = mode_q;
                end
                if (nxt_valid) begin
                    mode_n  = nxt_mode;
                    state_n = LAUNCH;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.mb_ready     = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.pred_start   = (state == LAUNCH);
    assign bus.result_valid = (state == DONE);
    assign bus.pred_mode    = mode_q;
    assign bus.best_mode    = bmode;
    assign bus.best_cost    = bcost;
    assign bus.timeout_err  = terr;

endmodule
